param_calc_core: RTL
====================

Name: param_calc_core

Overview:
- Parametrised W-bit arithmetic core for the board calculator. Computes add, subtract, multiply and square.
- Add/sub run in signed or unsigned mode; mult/sqr use a sequential shift-add multiplier.
- Takes a one-cycle start pulse from the button/selector logic and returns a registered result, sign and validity flag with a done pulse.
- Also drives the LED bank: binary result when valid, flashing when invalid. Feeds the seven-segment driver directly.

Parameters:
- W, 8, operand width in bits (W >= 2).
- FLASH_BIT, 25, bit of the free-running flash counter used as the LED blink source.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request pulse.
- op  input  2  operation: 00 add, 01 sub, 10 mult, 11 sqr.
- sgd  input  1  1 = signed add/sub. Ignored for mult/sqr.
- A  input  W  operand A.
- B  input  W  operand B. Ignored for sqr.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when a new result is committed.
- result  output  2W  magnitude of the result.
- neg  output  1  result is negative.
- valid  output  1  result representable (no overflow/underflow).
- led  output  W+1  {neg, result[W-1:0]} when valid, else all bits = flash.

Behaviour:
- One clock (clk). Reset is synchronous and active-high; reset has priority over start.
- Reset values: state IDLE, busy=0, done=0, result=0, neg=0, valid=0, flash counter=0, iteration count=0. LEDs therefore flash after reset.
- Reset mid-operation aborts it: no done pulse, and all outputs return to their reset values on that edge.
- FSM states are IDLE, ADDSUB, MUL.
- IDLE:
  - start=1 at edge k latches op, sgd, A, B (sqr latches B=A).
  - Next state is ADDSUB for op 0x, MUL for op 1x.
  - Operand changes after edge k have no effect.
- ADDSUB: one cycle. At edge k+1, result, neg and valid are written, done=1 for that one cycle, and state returns to IDLE. Latency is 1.
- MUL: W iterations, one per edge (k+1..k+W).
  - Each iteration: if the current multiplier LSB is 1, add the shifted multiplicand to the 2W-bit accumulator; then shift.
  - At edge k+W, result = product, neg=0, valid=1, done=1 for one cycle, state returns to IDLE. Latency is W.
- busy=1 exactly while in ADDSUB or MUL. start while busy is ignored (not queued).
- A start in the same cycle as done is accepted, because the FSM is already in IDLE.
- result, neg and valid hold their values between operations. They change only on a commit or on reset.
- Arithmetic rules (true = mathematically exact value):
  - Unsigned add: S=A+B over W+1 bits. result=S[W-1:0] zero-extended, neg=0, valid=~S[W].
  - Unsigned sub: if A>=B, result=A-B, neg=0, valid=1. Else result=(A-B) mod 2^W, neg=0, valid=0.
  - Signed add/sub: operands are two's complement.
    - true = A±B computed in W+1 bits; neg = sign of true.
    - result = |true| truncated to W bits, zero-extended.
    - valid = 0 if true lies outside [-2^(W-1), 2^(W-1)-1].
    - A true value of -2^(W-1) is valid with magnitude 2^(W-1).
  - Mult/sqr: unsigned. result = A*B (or A*A), exact in 2W bits, always valid.
- Flash counter: FLASH_BIT+1 bits, increments every cycle, wraps to 0. flash = counter[FLASH_BIT].
- led is combinational from the registered valid, neg, result and flash.

Test Plan:
1. W=8, unsigned add A=100, B=27, start pulse -> one cycle later done=1 for one cycle, result=127, neg=0, valid=1, led=9'h07F. Then A=200, B=100 -> result=44, valid=0, led bits all equal flash.
2. sgd=1, sub A=8'h05, B=8'h0A -> result=5, neg=1, valid=1, led=9'h105. Then add 8'h7F+8'h01 -> valid=0. Then sub 8'h80-8'h01 -> valid=0. Then add 8'hC0+8'hC0 (-128) -> result=128, neg=1, valid=1.
3. mult A=255, B=255 -> busy high exactly 8 cycles, done on the 8th edge after start, result=16'hFE01, valid=1. sqr A=12, B=99 -> result=144.
4. Extra start pulses with A/B changes during a mult -> ignored, original product returned. A start in the done cycle is accepted and its done follows at the correct latency.
5. reset asserted 3 cycles into a mult -> next edge: busy=0, done=0, result=0, valid=0, and no done pulse appears later. A following add start completes normally. start and reset together -> reset wins.
6. FLASH_BIT=2, valid=0 -> every led bit toggles every 4 cycles. After a valid commit, led shows the static value.

Source files
------------

// File: rtl/param_calc_core.sv
`default_nettype none
// ============================================================================
// Module      : param_calc_core
// Description : W-bit calculator core. Add/sub (signed or unsigned) finish in
//               one cycle; mult/sqr use a W-step shift-add multiplier. Drives
//               a registered result plus an LED bank that flashes on overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module param_calc_core #(
  parameter int W         = 8,
  parameter int FLASH_BIT = 25
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic           sgd,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic           neg,
  output logic           valid,
  output logic [W:0]     led
);

  localparam int c_CW = $clog2(W);
  localparam int c_FW = FLASH_BIT + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADDSUB = 2'd1,
    S_MUL    = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_load;
  logic            w_commit_as;
  logic            w_commit_mul;

  logic            r_sub;
  logic            r_sgd;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;        // second operand; doubles as the multiplier shift register
  logic [2*W-1:0]  r_mcand;
  logic [2*W-1:0]  r_acc;
  logic [c_CW-1:0] r_cnt;
  logic [c_FW-1:0] r_flash_cnt;

  logic            r_done;
  logic [2*W-1:0]  r_result;
  logic            r_neg;
  logic            r_valid;

  logic [W:0]      w_ea;
  logic [W:0]      w_eb;
  logic [W:0]      w_sum;
  logic [W:0]      w_mag;
  logic [W-1:0]    w_as_res;
  logic            w_as_neg;
  logic            w_as_valid;
  logic [2*W-1:0]  w_acc_nxt;

  // State register; reset wins over any pending start
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and per-cycle load/commit strobes
  always_comb begin
    w_next       = r_state;
    w_load       = 1'b0;
    w_commit_as  = 1'b0;
    w_commit_mul = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = op[1] ? S_MUL : S_ADDSUB;
        end
      end
      S_ADDSUB: begin
        w_commit_as = 1'b1;
        w_next      = S_IDLE;
      end
      S_MUL: begin
        if (r_cnt == c_CW'(W - 1)) begin
          w_commit_mul = 1'b1;
          w_next       = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Add/sub in W+1 bits. Unsigned: bit W is carry (add) or borrow (sub), and
  // either way a set bit W means the value does not fit. Signed: bit W is the
  // true sign and overflow shows as bits W and W-1 disagreeing.
  always_comb begin
    w_ea  = r_sgd ? {r_a[W-1], r_a} : {1'b0, r_a};
    w_eb  = r_sgd ? {r_b[W-1], r_b} : {1'b0, r_b};
    w_sum = r_sub ? (w_ea - w_eb) : (w_ea + w_eb);
    w_mag = w_sum[W] ? (~w_sum + 1'b1) : w_sum;
    if (r_sgd) begin
      w_as_res   = w_mag[W-1:0];
      w_as_neg   = w_sum[W];
      w_as_valid = (w_sum[W] == w_sum[W-1]);
    end else begin
      w_as_res   = w_sum[W-1:0];
      w_as_neg   = 1'b0;
      w_as_valid = ~w_sum[W];
    end
    w_acc_nxt = r_acc + (r_b[0] ? r_mcand : {(2*W){1'b0}});
  end

  // Operand latch, multiplier iteration and result commit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sub    <= 1'b0;
      r_sgd    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_neg    <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_done <= w_commit_as | w_commit_mul;
      if (w_load) begin
        r_sub   <= op[0];
        r_sgd   <= sgd;
        r_a     <= A;
        r_b     <= (op == 2'b11) ? A : B;
        r_mcand <= {{W{1'b0}}, A};
        r_acc   <= '0;
        r_cnt   <= '0;
      end else if (r_state == S_MUL) begin
        r_acc   <= w_acc_nxt;
        r_mcand <= r_mcand << 1;
        r_b     <= r_b >> 1;
        r_cnt   <= r_cnt + c_CW'(1);
      end
      if (w_commit_as) begin
        r_result <= {{W{1'b0}}, w_as_res};
        r_neg    <= w_as_neg;
        r_valid  <= w_as_valid;
      end else if (w_commit_mul) begin
        r_result <= w_acc_nxt;
        r_neg    <= 1'b0;
        r_valid  <= 1'b1;
      end
    end
  end

  // Free-running blink source for the LED bank
  always_ff @(posedge clk) begin
    if (reset) r_flash_cnt <= '0;
    else       r_flash_cnt <= r_flash_cnt + c_FW'(1);
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;
  assign result = r_result;
  assign neg    = r_neg;
  assign valid  = r_valid;
  assign led    = r_valid ? {r_neg, r_result[W-1:0]} : {(W+1){r_flash_cnt[FLASH_BIT]}};

endmodule
`default_nettype wire
